div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Parameters
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 SHALL provide parameter TAG_W, default 5, width of the opaque tag carried with each operation (e.g. destination register).

Interface
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_signed  input  1  1 = signed (two's complement), 0 = unsigned.
REQ-008 in_dividend  input  WIDTH  dividend.
REQ-009 in_divisor  input  WIDTH  divisor.
REQ-010 in_tag  input  TAG_W  tag, returned unchanged with the result.
REQ-011 flush  input  1  synchronous cancel of any in-flight or completed-but-unconsumed operation.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_quot  output  WIDTH  quotient.
REQ-015 out_rem  output  WIDTH  remainder.
REQ-016 out_tag  output  TAG_W  tag of the completed operation.
REQ-017 out_div_zero  output  1  the completed operation had divisor == 0.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement an FSM with states IDLE, BUSY and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-020 Acceptance SHALL occur on an edge where in_valid && in_ready && !flush; operands, mode and tag are captured at that edge.
REQ-021 On acceptance with divisor != 0 the FSM SHALL enter BUSY and perform one restoring-division step per cycle on operand magnitudes, using an iteration counter of clog2(WIDTH+1) bits.
REQ-022 After exactly WIDTH BUSY iterations the FSM SHALL enter DONE, so out_valid rises WIDTH cycles after the acceptance edge.
REQ-023 In signed mode, magnitudes SHALL be formed at acceptance; the quotient is negated when operand signs differ and the remainder takes the sign of the dividend (truncation toward zero). Sign correction SHALL complete before out_valid rises.
REQ-024 The signed case most-negative / -1 SHALL produce quot = most-negative value and rem = 0, with no error flag.
REQ-025 When divisor == 0 at acceptance, the FSM SHALL enter DONE directly (out_valid one cycle after acceptance) with quot = all ones, rem = dividend unchanged, and out_div_zero = 1. In every other case out_div_zero = 0.
REQ-026 In DONE, out_quot, out_rem, out_tag and out_div_zero SHALL stay stable until the edge where out_valid && out_ready; at that edge the FSM returns to IDLE.
REQ-027 in_ready SHALL be low during the cycle in which the result is consumed, so there is no same-cycle consume and accept.
REQ-028 flush SHALL override all other inputs: at the next edge the FSM goes to IDLE from any state, the counter clears, and no result is presented.
REQ-029 A request presented together with flush SHALL NOT be accepted.
REQ-030 Input values other than in_valid and flush SHALL be ignored outside the acceptance edge; changes during BUSY SHALL not affect the result.

Reset
REQ-031 While resetn is low, the block SHALL immediately set state = IDLE, counter = 0, and out_quot, out_rem, out_tag and out_div_zero to 0; consequently out_valid = 0, busy = 0 and in_ready = 1.
REQ-032 Reset asserted mid-operation SHALL discard that operation; after release, the first request SHALL be serviced with full normal latency.

Verification (WIDTH=32, TAG_W=5)
REQ-033 Unsigned case: 100 / 7, tag 3 -> out_valid exactly 32 cycles after acceptance with quot = 14, rem = 2, tag = 3, div_zero = 0.
REQ-034 Signed cases: -7 / 2 -> quot = 0xFFFFFFFD, rem = 0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF -> quot = 0x80000000, rem = 0.
REQ-035 Unsigned 0xFFFFFFFF / 0xFFFFFFFF -> quot = 1, rem = 0. Divide by zero, 5 / 0 -> out_valid after 1 cycle with quot = 0xFFFFFFFF, rem = 5, div_zero = 1.
REQ-036 Back-pressure: hold out_ready low for 5 cycles in DONE -> outputs stable and in_ready low throughout; on consume, IDLE follows and the next request is accepted one cycle later.
REQ-037 Flush: assert flush on BUSY iteration 10 -> next cycle in_ready = 1 and busy = 0, and out_valid never rises. A new 9 / 3 request then yields quot = 3, rem = 0.
REQ-038 Reset: pulse resetn low asynchronously (between clock edges) mid-BUSY -> outputs clear immediately without waiting for a clock edge; the post-reset request 100 / 7 completes normally.

Source files
------------

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with a valid/ready request port and a valid/ready result port.
module div_iter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quot,
   output logic [WIDTH-1:0] out_rem,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_div_zero,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   quot_r;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   dvsr_r;
   logic               neg_q_r;
   logic               neg_r_r;
   logic [TAG_W-1:0]   tag_r;
   logic [WIDTH-1:0]   out_quot_r;
   logic [WIDTH-1:0]   out_rem_r;
   logic [TAG_W-1:0]   out_tag_r;
   logic               out_div_zero_r;

   logic               accept_s;
   logic               div_zero_s;
   logic               last_s;
   logic [WIDTH:0]     shift_s;
   logic [WIDTH:0]     diff_s;
   logic               q_bit_s;
   logic [WIDTH-1:0]   rem_nxt_s;
   logic [WIDTH-1:0]   quot_nxt_s;
   logic [WIDTH-1:0]   quot_fin_s;
   logic [WIDTH-1:0]   rem_fin_s;
   logic               in_ready_s;
   logic               out_valid_s;
   logic               busy_s;

   function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
      return (~v) + WIDTH'(1);
   endfunction

   // The most-negative value maps to itself, which reads correctly as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic sgn);
      if (sgn && v[WIDTH-1]) begin
         return neg_f(v);
      end else begin
         return v;
      end
   endfunction

   assign accept_s   = in_valid && (state_r == IDLE) && !flush;
   assign div_zero_s = (in_divisor == {WIDTH{1'b0}});
   assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; flush wins over everything
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_nxt_s = div_zero_s ? DONE : BUSY;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            BUSY: begin
               if (last_s) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = BUSY;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = DONE;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // FSM output decode
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      busy_s      = 1'b1;
      case (state_r)
         IDLE: begin
            in_ready_s = 1'b1;
            busy_s     = 1'b0;
         end
         BUSY:    busy_s      = 1'b1;
         DONE:    out_valid_s = 1'b1;
         default: busy_s      = 1'b1;
      endcase
   end

   // One restoring step: shift in the next dividend bit and trial-subtract
   always_comb begin
      shift_s = {rem_r, quot_r[WIDTH-1]};
      diff_s  = shift_s - {1'b0, dvsr_r};
      q_bit_s = !diff_s[WIDTH];
      if (q_bit_s) begin
         rem_nxt_s = diff_s[WIDTH-1:0];
      end else begin
         rem_nxt_s = shift_s[WIDTH-1:0];
      end
      quot_nxt_s = {quot_r[WIDTH-2:0], q_bit_s};
   end

   // Sign correction applied to the final step so results are ready with out_valid
   always_comb begin
      if (neg_q_r) begin
         quot_fin_s = neg_f(quot_nxt_s);
      end else begin
         quot_fin_s = quot_nxt_s;
      end
      if (neg_r_r) begin
         rem_fin_s = neg_f(rem_nxt_s);
      end else begin
         rem_fin_s = rem_nxt_s;
      end
   end

   // Iteration counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (flush || (state_r != BUSY) || last_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Operand capture at acceptance, then shift/subtract while BUSY
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         quot_r  <= {WIDTH{1'b0}};
         rem_r   <= {WIDTH{1'b0}};
         dvsr_r  <= {WIDTH{1'b0}};
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         tag_r   <= {TAG_W{1'b0}};
      end else if (accept_s) begin
         quot_r  <= mag_f(in_dividend, in_signed);
         rem_r   <= {WIDTH{1'b0}};
         dvsr_r  <= mag_f(in_divisor, in_signed);
         neg_q_r <= in_signed && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
         neg_r_r <= in_signed && in_dividend[WIDTH-1];
         tag_r   <= in_tag;
      end else if (state_r == BUSY) begin
         quot_r <= quot_nxt_s;
         rem_r  <= rem_nxt_s;
      end else begin
         quot_r <= quot_r;
         rem_r  <= rem_r;
      end
   end

   // Result registers, written only when an operation completes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_quot_r     <= {WIDTH{1'b0}};
         out_rem_r      <= {WIDTH{1'b0}};
         out_tag_r      <= {TAG_W{1'b0}};
         out_div_zero_r <= 1'b0;
      end else if (accept_s && div_zero_s) begin
         out_quot_r     <= {WIDTH{1'b1}};
         out_rem_r      <= in_dividend;
         out_tag_r      <= in_tag;
         out_div_zero_r <= 1'b1;
      end else if ((state_r == BUSY) && last_s && !flush) begin
         out_quot_r     <= quot_fin_s;
         out_rem_r      <= rem_fin_s;
         out_tag_r      <= tag_r;
         out_div_zero_r <= 1'b0;
      end else begin
         out_quot_r     <= out_quot_r;
         out_rem_r      <= out_rem_r;
         out_tag_r      <= out_tag_r;
         out_div_zero_r <= out_div_zero_r;
      end
   end

   assign in_ready     = in_ready_s;
   assign out_valid    = out_valid_s;
   assign busy         = busy_s;
   assign out_quot     = out_quot_r;
   assign out_rem      = out_rem_r;
   assign out_tag      = out_tag_r;
   assign out_div_zero = out_div_zero_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter (WIDTH=32, TAG_W=5): latency, signed/unsigned
// results, divide-by-zero, back-pressure, flush and asynchronous reset.
module tb_div_iter;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic        in_signed;
   logic [31:0] in_dividend;
   logic [31:0] in_divisor;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_quot;
   logic [31:0] out_rem;
   logic [4:0]  out_tag;
   logic        out_div_zero;
   logic        busy;

   int n_eval;
   int n_fail;
   int lat;
   int seen;

   div_iter #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor),
      .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_quot(out_quot), .out_rem(out_rem), .out_tag(out_tag),
      .out_div_zero(out_div_zero), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge, then scramble operands to prove they are ignored.
   task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      in_valid = 1'b1; in_signed = sgn; in_dividend = a; in_divisor = b; in_tag = tag;
      @(posedge clk); #1;
      in_valid = 1'b0; in_signed = ~sgn;
      in_dividend = $urandom; in_divisor = $urandom; in_tag = 5'(~tag);
   endtask

   // Edges after the acceptance edge until out_valid, bounded at 100.
   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic do_op(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input int exp_lat,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez);
      int n;
      start(sgn, a, b, tag);
      wait_done(n);
      chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
      chk({nm, "_quot"}, 64'(out_quot), 64'(eq));
      chk({nm, "_rem"}, 64'(out_rem), 64'(er));
      chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
      chk({nm, "_dz"}, 64'(out_div_zero), 64'(ez));
      consume();
      chk({nm, "_idle"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      n_eval = 0; n_fail = 0;
      resetn = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_dividend = 32'd0;
      in_divisor = 32'd0; in_tag = 5'd0; flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_quot", 64'(out_quot), 64'd0);
      chk("rst_rem", 64'(out_rem), 64'd0);
      chk("rst_dz", 64'(out_div_zero), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;

      // Main function; divide-by-zero enters DONE on the acceptance edge itself
      do_op("u100_7", 1'b0, 32'd100, 32'd7, 5'd3, 32, 32'd14, 32'd2, 1'b0);
      do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      do_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd5, 32, 32'hFFFF_FFFD, 32'd1, 1'b0);
      do_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32, 32'h8000_0000, 32'd0, 1'b0);
      do_op("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32, 32'd1, 32'd0, 1'b0);
      do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd8, 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
      do_op("dz_5_0", 1'b0, 32'd5, 32'd0, 5'd9, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      do_op("dz_sgn", 1'b1, 32'hFFFF_FFF0, 32'd0, 5'd10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);

      // Back-pressure: result held, no accept in the consume cycle
      start(1'b0, 32'd1000, 32'd10, 5'd11);
      wait_done(lat);
      chk("bp_lat", 64'(lat), 64'd32);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_quot", 64'(out_quot), 64'd100);
         chk("bp_rem", 64'(out_rem), 64'd0);
         chk("bp_tag", 64'(out_tag), 64'd11);
      end
      out_ready = 1'b1;
      in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd50; in_divisor = 32'd5; in_tag = 5'd12;
      #1;
      chk("bp_consume_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_after_valid", 64'(out_valid), 64'd0);
      chk("bp_after_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_accepted", 64'(busy), 64'd1);
      wait_done(lat);
      chk("bp_next_lat", 64'(lat), 64'd32);
      chk("bp_next_quot", 64'(out_quot), 64'd10);
      chk("bp_next_tag", 64'(out_tag), 64'd12);
      consume();

      // Flush on BUSY iteration 10
      start(1'b0, 32'd1234, 32'd5, 5'd1);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      chk("fl_busy", 64'(busy), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("fl_no_valid", 64'(seen), 64'd0);
      // Request presented together with flush is refused
      in_valid = 1'b1; flush = 1'b1; in_dividend = 32'd9; in_divisor = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("fl_req_refused", 64'(busy), 64'd0);
      // Flush in DONE drops the pending result
      start(1'b0, 32'd5, 32'd0, 5'd2);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_done_valid", 64'(out_valid), 64'd0);
      do_op("fl_9_3", 1'b0, 32'd9, 32'd3, 5'd13, 32, 32'd3, 32'd0, 1'b0);

      // Asynchronous reset mid-BUSY between clock edges
      start(1'b0, 32'd77, 32'd3, 5'd14);
      repeat (5) begin @(posedge clk); #1; end
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_in_ready", 64'(in_ready), 64'd1);
      chk("ar_quot", 64'(out_quot), 64'd0);
      chk("ar_tag", 64'(out_tag), 64'd0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      do_op("ar_100_7", 1'b0, 32'd100, 32'd7, 5'd3, 32, 32'd14, 32'd2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
